// File: rtl/cus19_ctrl_pkg.sv
// rtl/cus19_ctrl_pkg.sv - opcode/funct codes, state encoding and pc_src codes for the CUS19 multi-cycle control unit
package cus19_ctrl_pkg;

  // Opcode values (compared after resizing to OPC_W)
  localparam int OPC_R   = 0;
  localparam int OPC_M   = 1;
  localparam int OPC_J   = 2;
  localparam int OPC_B   = 3;
  localparam int OPC_S   = 4;
  localparam int OPC_SYS = 7;

  // Funct values within each opcode group (compared after resizing to FUNCT_W)
  localparam int FN_STORE = 0;
  localparam int FN_LOAD  = 1;
  localparam int FN_JUMP  = 0;
  localparam int FN_CALL  = 1;
  localparam int FN_RET   = 2;
  localparam int FN_BEQ   = 0;
  localparam int FN_ENC   = 0;
  localparam int FN_DEC   = 1;
  localparam int FN_HALT  = 0;

  // FSM state encoding, also exported on state_out for debug
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_CRYPTO = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  // Next-PC source select driven during write-back
  localparam logic [2:0] PC_SRC_INC    = 3'd0;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd1;
  localparam logic [2:0] PC_SRC_CALL   = 3'd2;
  localparam logic [2:0] PC_SRC_RET    = 3'd3;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd4;

  // Instruction class produced by the decoder; CLS_NONE marks an illegal encoding
  typedef enum logic [3:0] {
    CLS_R,
    CLS_STORE,
    CLS_LOAD,
    CLS_JUMP,
    CLS_CALL,
    CLS_RET,
    CLS_BEQ,
    CLS_ENC,
    CLS_DEC,
    CLS_HALT,
    CLS_NONE
  } ins_class_t;

endpackage

// File: rtl/cus19_ctrl_decoder.sv
// rtl/cus19_ctrl_decoder.sv - combinational opcode/funct classifier with illegal-encoding flag
module cus19_ctrl_decoder
  import cus19_ctrl_pkg::*;
#(
  parameter int OPC_W   = 3,
  parameter int FUNCT_W = 4
) (
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  output ins_class_t         ins_class,
  output logic               illegal
);

  // Map each legal opcode/funct pair to its class; anything else stays CLS_NONE
  always_comb begin
    ins_class = CLS_NONE;
    if (opcode == OPC_W'(OPC_R)) begin
      ins_class = CLS_R;
    end else if (opcode == OPC_W'(OPC_M)) begin
      if (funct == FUNCT_W'(FN_STORE))     ins_class = CLS_STORE;
      else if (funct == FUNCT_W'(FN_LOAD)) ins_class = CLS_LOAD;
    end else if (opcode == OPC_W'(OPC_J)) begin
      if (funct == FUNCT_W'(FN_JUMP))      ins_class = CLS_JUMP;
      else if (funct == FUNCT_W'(FN_CALL)) ins_class = CLS_CALL;
      else if (funct == FUNCT_W'(FN_RET))  ins_class = CLS_RET;
    end else if (opcode == OPC_W'(OPC_B)) begin
      if (funct == FUNCT_W'(FN_BEQ))       ins_class = CLS_BEQ;
    end else if (opcode == OPC_W'(OPC_S)) begin
      if (funct == FUNCT_W'(FN_ENC))       ins_class = CLS_ENC;
      else if (funct == FUNCT_W'(FN_DEC))  ins_class = CLS_DEC;
    end else if (opcode == OPC_W'(OPC_SYS)) begin
      if (funct == FUNCT_W'(FN_HALT))      ins_class = CLS_HALT;
    end
  end

  assign illegal = (ins_class == CLS_NONE);

endmodule

// File: rtl/cus19_multicycle_ctrl.sv
// rtl/cus19_multicycle_ctrl.sv - multi-cycle CUS19 control FSM; CUS19_CTRL_TIMEOUT_EN enables wait-state timeout traps
module cus19_multicycle_ctrl
  import cus19_ctrl_pkg::*;
#(
  parameter int OPC_W          = 3,
  parameter int FUNCT_W        = 4,
  parameter int MEM_TIMEOUT    = 15,
  parameter int CRYPTO_TIMEOUT = 255
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [OPC_W-1:0]   opcode_in,
  input  logic [FUNCT_W-1:0] funct_in,
  input  logic               mem_ready_in,
  input  logic               crypto_done_in,
  input  logic               branch_taken_in,
  output logic               ir_load_out,
  output logic               pc_wr_out,
  output logic [2:0]         pc_src_out,
  output logic               alu_en_out,
  output logic               mem_rd_out,
  output logic               mem_wr_out,
  output logic               reg_wr_out,
  output logic               wr_back_sel_out,
  output logic               branch_en_out,
  output logic               crypto_start_out,
  output logic               mode_enc_dec_out,
  output logic               illegal_op_out,
  output logic               timeout_out,
  output logic               busy_out,
  output logic [2:0]         state_out
);

  logic [2:0]         state_q;
  logic [2:0]         state_d;
  logic [OPC_W-1:0]   opc_q;
  logic [FUNCT_W-1:0] funct_q;
  logic               taken_q;
  logic               crypto_started_q;
  logic               illegal_q;
  logic               timeout_q;
  logic               wait_expired;

  // In DECODE the live instruction bits drive the branch; afterwards the latched copy does
  logic [OPC_W-1:0]   dec_opc;
  logic [FUNCT_W-1:0] dec_funct;
  ins_class_t         cls;
  logic               cls_illegal;

  assign dec_opc   = (state_q == ST_DECODE) ? opcode_in : opc_q;
  assign dec_funct = (state_q == ST_DECODE) ? funct_in  : funct_q;

  cus19_ctrl_decoder #(
    .OPC_W   (OPC_W),
    .FUNCT_W (FUNCT_W)
  ) u_decoder (
    .opcode    (dec_opc),
    .funct     (dec_funct),
    .ins_class (cls),
    .illegal   (cls_illegal)
  );

`ifdef CUS19_CTRL_TIMEOUT_EN
  logic [7:0] wait_cnt_q;
  logic [7:0] wait_limit;

  // The limit-th waiting cycle without a handshake expires; a same-cycle handshake still wins
  assign wait_limit   = (state_q == ST_CRYPTO) ? 8'(CRYPTO_TIMEOUT - 1) : 8'(MEM_TIMEOUT - 1);
  assign wait_expired = (wait_cnt_q == wait_limit);

  // Wait counter restarts on every state change and counts cycles spent in the same state
  always_ff @(posedge clk_in) begin
    if (rst_in)                  wait_cnt_q <= 8'd0;
    else if (state_d != state_q) wait_cnt_q <= 8'd0;
    else                         wait_cnt_q <= wait_cnt_q + 8'd1;
  end

  // Any trap not taken from DECODE comes from an expired wait
  always_ff @(posedge clk_in) begin
    if (rst_in) timeout_q <= 1'b0;
    else        timeout_q <= timeout_q | ((state_d == ST_TRAP) && (state_q != ST_TRAP) && (state_q != ST_DECODE));
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (MEM_TIMEOUT == 0) ^ (CRYPTO_TIMEOUT == 0);
  assign wait_expired       = 1'b0;
  assign timeout_q          = 1'b0;
`endif

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready_in)      state_d = ST_DECODE;
        else if (wait_expired) state_d = ST_TRAP;
      end
      ST_DECODE: begin
        if (cls_illegal) begin
          state_d = ST_TRAP;
        end else begin
          case (cls)
            CLS_LOAD, CLS_STORE: state_d = ST_MEM;
            CLS_ENC, CLS_DEC:    state_d = ST_CRYPTO;
            CLS_HALT:            state_d = ST_HALT;
            default:             state_d = ST_EXEC;
          endcase
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_MEM: begin
        if (mem_ready_in)      state_d = ST_WB;
        else if (wait_expired) state_d = ST_TRAP;
      end
      ST_CRYPTO: begin
        if (crypto_started_q && crypto_done_in) state_d = ST_WB;
        else if (wait_expired)                  state_d = ST_TRAP;
      end
      ST_WB:   state_d = ST_FETCH;
      default: state_d = state_q;
    endcase
  end

  // State, instruction latch, branch outcome, crypto start tracking and illegal flag
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q          <= ST_FETCH;
      opc_q            <= '0;
      funct_q          <= '0;
      taken_q          <= 1'b0;
      crypto_started_q <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        opc_q   <= opcode_in;
        funct_q <= funct_in;
      end
      if (state_q == ST_EXEC) taken_q <= branch_taken_in;
      crypto_started_q <= (state_q == ST_CRYPTO) && (state_d == ST_CRYPTO);
      illegal_q        <= illegal_q | ((state_q == ST_DECODE) && (state_d == ST_TRAP));
    end
  end

  // Moore output decode; everything is forced quiet while reset is held
  always_comb begin
    ir_load_out      = 1'b0;
    pc_wr_out        = 1'b0;
    pc_src_out       = PC_SRC_INC;
    alu_en_out       = 1'b0;
    mem_rd_out       = 1'b0;
    mem_wr_out       = 1'b0;
    reg_wr_out       = 1'b0;
    wr_back_sel_out  = 1'b0;
    branch_en_out    = 1'b0;
    crypto_start_out = 1'b0;
    mode_enc_dec_out = 1'b0;
    if (!rst_in) begin
      case (state_q)
        ST_FETCH: begin
          mem_rd_out  = 1'b1;
          ir_load_out = mem_ready_in;
        end
        ST_EXEC: begin
          alu_en_out    = (cls == CLS_R) || (cls == CLS_BEQ);
          branch_en_out = (cls == CLS_BEQ);
        end
        ST_MEM: begin
          mem_rd_out = (cls == CLS_LOAD);
          mem_wr_out = (cls == CLS_STORE);
        end
        ST_CRYPTO: begin
          crypto_start_out = !crypto_started_q;
          mode_enc_dec_out = (cls == CLS_DEC);
        end
        ST_WB: begin
          pc_wr_out       = 1'b1;
          reg_wr_out      = (cls == CLS_R) || (cls == CLS_LOAD);
          wr_back_sel_out = (cls == CLS_LOAD);
          case (cls)
            CLS_JUMP: pc_src_out = PC_SRC_JUMP;
            CLS_CALL: pc_src_out = PC_SRC_CALL;
            CLS_RET:  pc_src_out = PC_SRC_RET;
            CLS_BEQ:  pc_src_out = taken_q ? PC_SRC_BRANCH : PC_SRC_INC;
            default:  pc_src_out = PC_SRC_INC;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign illegal_op_out = illegal_q & ~rst_in;
  assign timeout_out    = timeout_q & ~rst_in;
  assign busy_out       = rst_in | ~((state_q == ST_HALT) || (state_q == ST_TRAP));
  assign state_out      = rst_in ? ST_FETCH : state_q;

endmodule

// File: tb/tb_cus19_multicycle_ctrl.sv
// tb/tb_cus19_multicycle_ctrl.sv - randomized self-checking bench for cus19_multicycle_ctrl against a per-instruction cycle model
module tb_cus19_multicycle_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [2:0] opcode_in = 3'd0;
  logic [3:0] funct_in = 4'd0;
  logic       mem_ready_in = 1'b0;
  logic       crypto_done_in = 1'b0;
  logic       branch_taken_in = 1'b0;
  logic       ir_load_out, pc_wr_out, alu_en_out, mem_rd_out, mem_wr_out, reg_wr_out;
  logic       wr_back_sel_out, branch_en_out, crypto_start_out, mode_enc_dec_out;
  logic       illegal_op_out, timeout_out, busy_out;
  logic [2:0] pc_src_out, state_out;

  always #5 clk_in = ~clk_in;

  cus19_multicycle_ctrl dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .opcode_in        (opcode_in),
    .funct_in         (funct_in),
    .mem_ready_in     (mem_ready_in),
    .crypto_done_in   (crypto_done_in),
    .branch_taken_in  (branch_taken_in),
    .ir_load_out      (ir_load_out),
    .pc_wr_out        (pc_wr_out),
    .pc_src_out       (pc_src_out),
    .alu_en_out       (alu_en_out),
    .mem_rd_out       (mem_rd_out),
    .mem_wr_out       (mem_wr_out),
    .reg_wr_out       (reg_wr_out),
    .wr_back_sel_out  (wr_back_sel_out),
    .branch_en_out    (branch_en_out),
    .crypto_start_out (crypto_start_out),
    .mode_enc_dec_out (mode_enc_dec_out),
    .illegal_op_out   (illegal_op_out),
    .timeout_out      (timeout_out),
    .busy_out         (busy_out),
    .state_out        (state_out)
  );

  localparam int K_R = 0, K_ST = 1, K_LD = 2, K_J = 3, K_B = 4, K_S = 5, K_HALT = 6, K_TRAP = 7;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected outputs for the cycle about to be checked
  logic [2:0] e_state, e_pc_src;
  logic e_ir_load, e_pc_wr, e_alu_en, e_mem_rd, e_mem_wr, e_reg_wr, e_wb_sel;
  logic e_branch_en, e_start, e_mode, e_illegal, e_timeout, e_busy;
  logic sticky_ill = 1'b0;
  logic sticky_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic int kind_of(input logic [2:0] o, input logic [3:0] f);
    case (o)
      3'd0: return K_R;
      3'd1: return (f == 0) ? K_ST : (f == 1) ? K_LD : K_TRAP;
      3'd2: return (f <= 2) ? K_J : K_TRAP;
      3'd3: return (f == 0) ? K_B : K_TRAP;
      3'd4: return (f <= 1) ? K_S : K_TRAP;
      3'd7: return (f == 0) ? K_HALT : K_TRAP;
      default: return K_TRAP;
    endcase
  endfunction

  // Quiet expectation for a given state; HALT and TRAP drop busy
  task automatic idle(input logic [2:0] s);
    e_state = s; e_pc_src = 3'd0;
    e_ir_load = 0; e_pc_wr = 0; e_alu_en = 0; e_mem_rd = 0; e_mem_wr = 0; e_reg_wr = 0; e_wb_sel = 0;
    e_branch_en = 0; e_start = 0; e_mode = 0;
    e_illegal = sticky_ill; e_timeout = sticky_to;
    e_busy = (s != 3'd6) && (s != 3'd7);
  endtask

  // One clock: drive inputs mid-low-phase, compare all outputs before the next rising edge
  task automatic cyc(input string tag, input logic rst, input logic rdy, input logic done, input logic tk,
                     input logic [2:0] opc, input logic [3:0] fn);
    logic [31:0] got, exp;
    @(negedge clk_in);
    rst_in = rst; mem_ready_in = rdy; crypto_done_in = done; branch_taken_in = tk;
    opcode_in = opc; funct_in = fn;
    #1;
    got = {13'd0, state_out, ir_load_out, pc_wr_out, pc_src_out, alu_en_out, mem_rd_out, mem_wr_out,
           reg_wr_out, wr_back_sel_out, branch_en_out, crypto_start_out, mode_enc_dec_out,
           illegal_op_out, timeout_out, busy_out};
    exp = {13'd0, e_state, e_ir_load, e_pc_wr, e_pc_src, e_alu_en, e_mem_rd, e_mem_wr,
           e_reg_wr, e_wb_sel, e_branch_en, e_start, e_mode, e_illegal, e_timeout, e_busy};
    check(tag, got, exp);
  endtask

  task automatic noise(input string tag, input logic rst);
    cyc(tag, rst, rb(), rb(), rb(), 3'($urandom), 4'($urandom));
  endtask

  // While reset is held every output is quiet except busy
  task automatic do_reset();
    sticky_ill = 0; sticky_to = 0;
    idle(3'd0);
    noise("reset", 1'b1);
  endtask

  // Walk one instruction through the model: fw fetch waits, xw MEM/CRYPTO waits,
  // abort_at >= 0 asserts reset in that MEM cycle instead of continuing
  task automatic run_instr(input logic [2:0] opc, input logic [3:0] fn, input int fw, input int xw,
                           input logic early_done, input logic taken, input int abort_at);
    int k;
    k = kind_of(opc, fn);
    for (int i = 0; i <= fw; i++) begin
      idle(3'd0); e_mem_rd = 1; e_ir_load = (i == fw);
      cyc("fetch", 0, (i == fw), rb(), rb(), 3'($urandom), 4'($urandom));
    end
    idle(3'd1);
    cyc("decode", 0, rb(), rb(), rb(), opc, fn);
    case (k)
      K_R, K_J, K_B: begin
        idle(3'd2);
        e_alu_en = (k != K_J); e_branch_en = (k == K_B);
        cyc("exec", 0, rb(), rb(), taken, 3'($urandom), 4'($urandom));
      end
      K_LD, K_ST: begin
        for (int i = 0; i <= xw; i++) begin
          if (i == abort_at) begin
            do_reset();
            return;
          end
          idle(3'd3); e_mem_rd = (k == K_LD); e_mem_wr = (k == K_ST);
          cyc("mem", 0, (i == xw), rb(), rb(), 3'($urandom), 4'($urandom));
        end
      end
      K_S: begin
        for (int i = 0; i <= xw; i++) begin
          idle(3'd4); e_start = (i == 0); e_mode = fn[0];
          cyc("crypto", 0, rb(), (i == 0) ? early_done : (i == xw), rb(), 3'($urandom), 4'($urandom));
        end
      end
      K_HALT: begin
        idle(3'd6);
        for (int i = 0; i < 3; i++) noise("halt", 1'b0);
        do_reset();
        return;
      end
      default: begin
        sticky_ill = 1;
        idle(3'd7);
        for (int i = 0; i < 3; i++) noise("trap", 1'b0);
        do_reset();
        return;
      end
    endcase
    idle(3'd5);
    e_pc_wr = 1;
    e_reg_wr = (k == K_R) || (k == K_LD);
    e_wb_sel = (k == K_LD);
    if (k == K_J) e_pc_src = 3'(fn + 1);
    if (k == K_B && taken) e_pc_src = 3'd4;
    noise("wb", 1'b0);
  endtask

  logic [2:0] r_opc;
  logic [3:0] r_fn;
  logic [6:0] legal_pairs [9] = '{7'h00, 7'h10, 7'h11, 7'h20, 7'h21, 7'h22, 7'h30, 7'h40, 7'h41};

  initial begin
    do_reset();
    do_reset();

    // Directed cases
    run_instr(3'd0, 4'd6, 0, 0, 0, 0, -1);  // R decrement, zero wait
    run_instr(3'd1, 4'd1, 1, 3, 0, 0, -1);  // load, 3 wait cycles in MEM
    run_instr(3'd1, 4'd0, 0, 2, 0, 0, -1);  // store
    run_instr(3'd1, 4'd0, 0, 0, 0, 0, -1);  // store, zero wait
    run_instr(3'd2, 4'd0, 0, 0, 0, 0, -1);  // jump
    run_instr(3'd2, 4'd1, 0, 0, 0, 0, -1);  // call
    run_instr(3'd2, 4'd2, 0, 0, 0, 0, -1);  // return
    run_instr(3'd3, 4'd0, 0, 0, 0, 1, -1);  // BEQ taken
    run_instr(3'd3, 4'd0, 2, 0, 0, 0, -1);  // BEQ not taken
    run_instr(3'd4, 4'd1, 0, 5, 1, 0, -1);  // decrypt, done in start cycle then 5 later
    run_instr(3'd4, 4'd0, 0, 1, 0, 0, -1);  // encrypt, done in first sampled cycle
    run_instr(3'd1, 4'd1, 0, 9, 0, 0, 2);   // reset asserted mid-MEM
    run_instr(3'd0, 4'd0, 0, 0, 0, 0, -1);  // recovers normally after reset
    run_instr(3'd5, 4'd0, 0, 0, 0, 0, -1);  // illegal opcode
    run_instr(3'd1, 4'd2, 0, 0, 0, 0, -1);  // illegal M funct
    run_instr(3'd7, 4'd0, 0, 0, 0, 0, -1);  // HALT
    run_instr(3'd7, 4'd1, 0, 0, 0, 0, -1);  // 111 with nonzero funct traps

`ifdef CUS19_CTRL_TIMEOUT_EN
    // MEM never ready: 15 waiting cycles then TRAP with timeout
    run_instr(3'd0, 4'd0, 0, 0, 0, 0, -1);
    idle(3'd0); e_mem_rd = 1; e_ir_load = 1;
    cyc("to_fetch", 0, 1, 0, 0, 3'd0, 4'd0);
    idle(3'd1);
    cyc("to_decode", 0, 0, 0, 0, 3'd1, 4'd1);
    for (int i = 0; i < 15; i++) begin
      idle(3'd3); e_mem_rd = 1;
      cyc("to_mem", 0, 0, rb(), rb(), 3'($urandom), 4'($urandom));
    end
    sticky_to = 1;
    idle(3'd7);
    noise("to_trap", 1'b0);
    do_reset();
    // Ready on the 15th MEM cycle wins over the limit
    run_instr(3'd1, 4'd1, 0, 14, 0, 0, -1);
`endif

    // Randomized mix, mostly legal pairs with some arbitrary encodings
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8) begin
        {r_opc, r_fn} = legal_pairs[$urandom_range(0, 8)];
        if (r_opc == 3'd0) r_fn = 4'($urandom);
      end else begin
        r_opc = 3'($urandom);
        r_fn  = 4'($urandom_range(0, 3));
      end
      run_instr(r_opc, r_fn, $urandom_range(0, 4), $urandom_range(1, 6), rb(), rb(),
                ($urandom_range(0, 19) == 0) ? $urandom_range(0, 1) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
